// File: rtl/boss_palette_sequencer.sv
// Boss sprite colour controller: phase-selected palette banks with frame-timed hit flash
// and defeat fade-to-black, applied through a 2-stage pixel pipeline.
module boss_palette_sequencer #(
    parameter int          FLASH_FRAMES = 16,
    parameter int          FLASH_PERIOD = 2,
    parameter int          FADE_STEP    = 4,
    parameter logic [11:0] FLASH_COLOR  = 12'hFFF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_start,
    input  logic       hit,
    input  logic       defeat,
    input  logic [1:0] phase,
    input  logic       pix_valid,
    input  logic [3:0] pix_index,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       rgb_valid,
    output logic       transparent,
    output logic       busy,
    output logic       dead
);

    typedef enum logic [1:0] {ST_NORMAL, ST_FLASH, ST_FADE, ST_DEAD} state_t;

    localparam logic [11:0] PAL0 [16] = '{
        12'h111, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hEA7, 12'h0FF, 12'hF0F,
        12'h888, 12'h444, 12'hC84, 12'h48C, 12'h8C4, 12'h123, 12'h456, 12'h789};
    localparam logic [11:0] PAL1 [16] = '{
        12'h222, 12'h800, 12'h080, 12'h008, 12'h880, 12'h5C3, 12'h088, 12'h808,
        12'hCCC, 12'h222, 12'hA62, 12'h26A, 12'h6A2, 12'h321, 12'h654, 12'h987};
    localparam logic [11:0] PAL2 [16] = '{
        12'h333, 12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h3B9, 12'h80F, 12'h0F8,
        12'hAAA, 12'h666, 12'hE40, 12'h4E0, 12'h04E, 12'hFED, 12'hCBA, 12'h135};

    state_t      r_state, w_state_next;
    logic [1:0]  r_bank, w_bank_next;
    logic [7:0]  r_flash_cnt, w_flash_cnt_next;
    logic [3:0]  r_per_cnt, w_per_cnt_next;
    logic        r_flash_on, w_flash_on_next;
    logic [3:0]  r_step_cnt, w_step_cnt_next;
    logic [3:0]  r_level, w_level_next;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= ST_NORMAL;
            r_bank      <= 2'd0;
            r_flash_cnt <= 8'd0;
            r_per_cnt   <= 4'd0;
            r_flash_on  <= 1'b0;
            r_step_cnt  <= 4'd0;
            r_level     <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_bank      <= w_bank_next;
            r_flash_cnt <= w_flash_cnt_next;
            r_per_cnt   <= w_per_cnt_next;
            r_flash_on  <= w_flash_on_next;
            r_step_cnt  <= w_step_cnt_next;
            r_level     <= w_level_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_bank_next      = r_bank;
        w_flash_cnt_next = r_flash_cnt;
        w_per_cnt_next   = r_per_cnt;
        w_flash_on_next  = r_flash_on;
        w_step_cnt_next  = r_step_cnt;
        w_level_next     = r_level;

        // Bank is frozen once the defeat sequence starts.
        if (frame_start && r_state != ST_FADE && r_state != ST_DEAD)
            w_bank_next = (phase == 2'd0) ? 2'd0 : (phase == 2'd1) ? 2'd1 : 2'd2;

        case (r_state)
            ST_NORMAL, ST_FLASH: begin
                if (defeat) begin
                    w_state_next    = ST_FADE;
                    w_level_next    = 4'd0;
                    w_step_cnt_next = 4'd0;
                    w_flash_on_next = 1'b0;
                end else if (hit) begin
                    w_state_next     = ST_FLASH;
                    w_flash_cnt_next = 8'(FLASH_FRAMES);
                    w_per_cnt_next   = 4'd0;
                    w_flash_on_next  = 1'b1;
                end else if (frame_start && r_state == ST_FLASH) begin
                    w_flash_cnt_next = r_flash_cnt - 8'd1;
                    if (r_per_cnt == 4'(FLASH_PERIOD - 1)) begin
                        w_per_cnt_next  = 4'd0;
                        w_flash_on_next = ~r_flash_on;
                    end else begin
                        w_per_cnt_next = r_per_cnt + 4'd1;
                    end
                    if (r_flash_cnt == 8'd1) begin
                        w_state_next    = ST_NORMAL;
                        w_flash_on_next = 1'b0;
                    end
                end
            end
            ST_FADE: begin
                if (frame_start) begin
                    if (r_step_cnt == 4'(FADE_STEP - 1)) begin
                        w_step_cnt_next = 4'd0;
                        w_level_next    = r_level + 4'd1;
                        if (r_level == 4'd14)
                            w_state_next = ST_DEAD;
                    end else begin
                        w_step_cnt_next = r_step_cnt + 4'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    logic [11:0] w_rom_rgb;
    assign w_rom_rgb = (r_bank == 2'd0) ? PAL0[pix_index] :
                       (r_bank == 2'd1) ? PAL1[pix_index] : PAL2[pix_index];

    // Palette read register carries no reset so it can map onto block RAM.
    logic [11:0] r_s1_rgb;
    always_ff @(posedge Clk) begin
        if (pix_valid)
            r_s1_rgb <= w_rom_rgb;
    end

    logic        r_s1_valid, r_s1_transp, r_s1_flash_on;
    state_t      r_s1_state;
    logic [3:0]  r_s1_level;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_transp   <= 1'b0;
            r_s1_flash_on <= 1'b0;
            r_s1_state    <= ST_NORMAL;
            r_s1_level    <= 4'd0;
        end else begin
            r_s1_valid <= pix_valid;
            if (pix_valid) begin
                r_s1_transp   <= (pix_index == 4'd0);
                r_s1_flash_on <= r_flash_on;
                r_s1_state    <= r_state;
                r_s1_level    <= r_level;
            end
        end
    end

    logic [2:0][3:0] w_sat_ch;
    for (genvar gi = 0; gi < 3; gi++) begin : g_sat
        assign w_sat_ch[gi] = (r_s1_rgb[gi*4 +: 4] > r_s1_level) ?
                              (r_s1_rgb[gi*4 +: 4] - r_s1_level) : 4'd0;
    end

    logic [11:0] w_eff_rgb;
    always_comb begin
        w_eff_rgb = r_s1_rgb;
        if (!r_s1_transp) begin
            case (r_s1_state)
                ST_FLASH: if (r_s1_flash_on) w_eff_rgb = FLASH_COLOR;
                ST_FADE:  w_eff_rgb = w_sat_ch;
                ST_DEAD:  w_eff_rgb = 12'h000;
                default:  ;
            endcase
        end
    end

    logic [11:0] r_rgb;
    logic        r_valid, r_transp;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rgb    <= 12'h000;
            r_valid  <= 1'b0;
            r_transp <= 1'b0;
        end else begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rgb    <= w_eff_rgb;
                r_transp <= r_s1_transp;
            end
        end
    end

    assign red         = r_rgb[11:8];
    assign green       = r_rgb[7:4];
    assign blue        = r_rgb[3:0];
    assign rgb_valid   = r_valid;
    assign transparent = r_transp;
    assign busy        = (r_state == ST_FLASH) || (r_state == ST_FADE);
    assign dead        = (r_state == ST_DEAD);

endmodule

// File: tb/tb_boss_palette_sequencer.sv
// Directed bench for boss_palette_sequencer: pixels are scored through a queue of
// expected colours, control/status outputs are checked at fixed points.
module tb_boss_palette_sequencer;

    localparam int FF = 16;
    localparam int FP = 2;
    localparam int FS = 4;

    localparam logic [11:0] T0 [16] = '{
        12'h111, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'hEA7, 12'h0FF, 12'hF0F,
        12'h888, 12'h444, 12'hC84, 12'h48C, 12'h8C4, 12'h123, 12'h456, 12'h789};
    localparam logic [11:0] T1 [16] = '{
        12'h222, 12'h800, 12'h080, 12'h008, 12'h880, 12'h5C3, 12'h088, 12'h808,
        12'hCCC, 12'h222, 12'hA62, 12'h26A, 12'h6A2, 12'h321, 12'h654, 12'h987};
    localparam logic [11:0] T2 [16] = '{
        12'h333, 12'hF80, 12'h8F0, 12'h08F, 12'hF08, 12'h3B9, 12'h80F, 12'h0F8,
        12'hAAA, 12'h666, 12'hE40, 12'h4E0, 12'h04E, 12'hFED, 12'hCBA, 12'h135};

    logic       Clk = 1'b0;
    logic       Reset_n, frame_start, hit, defeat, pix_valid;
    logic [1:0] phase;
    logic [3:0] pix_index;
    logic [3:0] red, green, blue;
    logic       rgb_valid, transparent, busy, dead;

    always #5 Clk = ~Clk;

    boss_palette_sequencer #(
        .FLASH_FRAMES(FF), .FLASH_PERIOD(FP), .FADE_STEP(FS), .FLASH_COLOR(12'hFFF)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .hit(hit),
        .defeat(defeat), .phase(phase), .pix_valid(pix_valid), .pix_index(pix_index),
        .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid),
        .transparent(transparent), .busy(busy), .dead(dead)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        tr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    function automatic logic [11:0] pal(input int b, input logic [3:0] i);
        if (b == 0) return T0[i];
        if (b == 1) return T1[i];
        return T2[i];
    endfunction

    function automatic logic [11:0] fade(input logic [11:0] c, input int lvl);
        logic [11:0] r;
        int v;
        r = 12'h000;
        for (int ch = 0; ch < 3; ch++) begin
            v = int'(c[ch*4 +: 4]) - lvl;
            if (v < 0) v = 0;
            r[ch*4 +: 4] = 4'(v);
        end
        return r;
    endfunction

    function automatic logic [11:0] flash_exp(input int f, input logic [11:0] raw);
        return (((f / FP) % 2) == 0) ? 12'hFFF : raw;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output side of the scoreboard.
    always @(negedge Clk) begin
        if (rgb_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_pixel observed=%h%h%h/%b expected=none",
                       red, green, blue, transparent);
            end else begin
                mon_e = sb.pop_front();
                assert ({red, green, blue, transparent} === {mon_e.rgb, mon_e.tr}) n_pass++;
                else begin
                    n_fail++;
                    $error("FAIL pixel observed=%h%h%h/%b expected=%h/%b",
                           red, green, blue, transparent, mon_e.rgb, mon_e.tr);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        repeat (3) cyc();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        cyc();
        hit = 1'b0;
    endtask

    task automatic pulse_defeat();
        defeat = 1'b1;
        cyc();
        defeat = 1'b0;
    endtask

    task automatic pix(input logic [3:0] idx, input logic [11:0] exp_rgb);
        pix_valid = 1'b1;
        pix_index = idx;
        sb.push_back(exp_t'{rgb: exp_rgb, tr: (idx == 4'd0)});
        cyc();
        pix_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; hit = 1'b0; defeat = 1'b0;
        phase = 2'd0; pix_valid = 1'b0; pix_index = 4'd0;
        repeat (3) cyc();
        chk("reset_outputs", {red, green, blue, rgb_valid, transparent, busy, dead}, 16'h0000);
        Reset_n = 1'b1;
        cyc();

        // Latency: valid only two cycles after the pixel.
        pix(4'd5, pal(0, 4'd5));
        @(negedge Clk); chk("valid_n1", 16'(rgb_valid), 16'(0));
        @(negedge Clk); chk("valid_n2", 16'(rgb_valid), 16'(1));
        @(negedge Clk); chk("valid_n3", 16'(rgb_valid), 16'(0));
        pix(4'd0, pal(0, 4'd0));
        pix(4'd1, pal(0, 4'd1));
        pix(4'd2, pal(0, 4'd2));
        pix(4'd15, pal(0, 4'd15));
        drain();

        // Bank changes only at frame_start.
        phase = 2'd2;
        pix(4'd4, pal(0, 4'd4));
        drain();
        frame();
        pix(4'd4, pal(2, 4'd4));
        phase = 2'd3; frame();
        pix(4'd4, pal(2, 4'd4));
        phase = 2'd1; frame();
        pix(4'd4, pal(1, 4'd4));
        pix(4'd0, pal(1, 4'd0));
        phase = 2'd0; frame();
        pix(4'd4, pal(0, 4'd4));
        drain();

        // Single hit: 16 frames of alternating flash.
        pulse_hit();
        chk("flash_busy", 16'(busy), 16'(1));
        for (int f = 0; f < FF; f++) begin
            pix(4'd3, flash_exp(f, pal(0, 4'd3)));
            pix(4'd0, pal(0, 4'd0));
            drain();
            if (f == FF - 1) chk("flash_busy_last", 16'(busy), 16'(1));
            frame();
        end
        chk("flash_done_busy", 16'(busy), 16'(0));
        pix(4'd3, pal(0, 4'd3));
        drain();

        // Restart: hit coincides with the 10th frame_start and wins.
        pulse_hit();
        for (int f = 0; f < 10; f++) begin
            pix(4'd3, flash_exp(f, pal(0, 4'd3)));
            drain();
            if (f < 9) frame();
            else begin
                hit = 1'b1; frame_start = 1'b1;
                cyc();
                hit = 1'b0; frame_start = 1'b0;
            end
        end
        for (int g = 0; g < FF; g++) begin
            pix(4'd3, flash_exp(g, pal(0, 4'd3)));
            drain();
            if (g == FF - 1) chk("restart_busy_last", 16'(busy), 16'(1));
            frame();
        end
        chk("restart_done_busy", 16'(busy), 16'(0));

        // Simultaneous hit+defeat enters fade; hit/defeat/phase ignored during fade.
        hit = 1'b1; defeat = 1'b1;
        cyc();
        hit = 1'b0; defeat = 1'b0;
        chk("fade_busy", 16'(busy), 16'(1));
        pix(4'd5, 12'hEA7);
        drain();
        for (int f = 1; f <= 60; f++) begin
            if (f == 5) phase = 2'd2;
            frame();
            if (f == 7) pulse_hit();
            if (f == 10) pulse_defeat();
            if (f < 60) begin
                pix(4'd5, fade(pal(0, 4'd5), f / FS));
                pix(4'd0, pal(0, 4'd0));
                drain();
                if (f == 59) chk("fade_not_dead", 16'(dead), 16'(0));
            end
        end
        chk("dead_flag", 16'(dead), 16'(1));
        chk("dead_busy", 16'(busy), 16'(0));
        pix(4'd5, 12'h000);
        pix(4'd0, pal(0, 4'd0));
        pix(4'd1, 12'h000);
        drain();
        pulse_hit();
        pulse_defeat();
        frame();
        pix(4'd5, 12'h000);
        drain();
        chk("dead_sticky", 16'(dead), 16'(1));

        // Asynchronous reset in the middle of a fade.
        phase = 2'd0;
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        cyc();
        pulse_defeat();
        repeat (4) frame();
        pix(4'd5, 12'hD96);
        pix(4'd0, pal(0, 4'd0));
        drain();
        chk("pre_reset_busy", 16'(busy), 16'(1));
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {red, green, blue, rgb_valid, transparent, busy, dead}, 16'h0000);
        @(negedge Clk);
        Reset_n = 1'b1;
        phase = 2'd2;
        cyc();
        chk("post_reset_state", {14'd0, busy, dead}, 16'h0000);
        pix(4'd4, pal(0, 4'd4));
        drain();
        frame();
        pix(4'd4, pal(2, 4'd4));
        drain();

        chk("scoreboard_empty", 16'(sb.size()), 16'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
